// File: rtl/spi_dac_wavegen.sv
// spi_dac_wavegen: multi-channel SPI DAC waveform generator.
// Round-robin {ch, sample} frames, MSB first; sawtooth/triangle/DC modes.
module spi_dac_wavegen #(
  parameter int DATA_BITS = 12,
  parameter int ADDR_BITS = 4,
  parameter int NUM_CH    = 4,
  parameter int T_CSH     = 2,
  parameter int T_CSS     = 1,
  parameter int T_HALF    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DATA_BITS-1:0] step,
  output logic                 CS,
  output logic                 SCLK,
  output logic                 SDO,
  output logic                 frame_done,
  output logic [ADDR_BITS-1:0] ch_idx
);

  localparam int FB = ADDR_BITS + DATA_BITS;
  localparam int CMAX = (T_CSH > T_CSS)
    ? ((T_CSH > T_HALF) ? T_CSH : T_HALF)
    : ((T_CSS > T_HALF) ? T_CSS : T_HALF);
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = $clog2(FB);

  localparam logic [DATA_BITS-1:0] MAXV = '1;
  localparam logic [DATA_BITS-1:0] OFS =
    DATA_BITS'((1 << DATA_BITS) / NUM_CH);
  localparam logic [ADDR_BITS-1:0] LAST_CH = ADDR_BITS'(NUM_CH - 1);

  localparam logic [1:0] M_SAW = 2'b00;
  localparam logic [1:0] M_TRI = 2'b01;
  localparam logic [1:0] M_DIR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CSH, S_CSS, S_LOW, S_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [FB-1:0]        shift_q, shift_d;
  logic [DATA_BITS-1:0] acc_q, acc_d;
  logic                 dir_q, dir_d;
  logic [ADDR_BITS-1:0] ch_q, ch_d;
  logic [ADDR_BITS-1:0] ch_idx_q, ch_idx_d;
  logic [1:0]           mode_q, mode_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic                 sdo_q, sdo_d;
  logic                 done_q, done_d;

  logic [1:0]           mode_eff;
  logic [DATA_BITS-1:0] ofs;
  logic [DATA_BITS-1:0] sample;
  logic [FB-1:0]        word;
  logic [DATA_BITS:0]   sum;
  logic [DATA_BITS-1:0] acc_nx;
  logic                 dir_nx;

  // The ch 0 frame samples mode directly; later frames reuse the latch.
  always_comb begin
    mode_eff = (ch_q == '0) ? mode : mode_q;
    ofs = DATA_BITS'(ch_q) * OFS;
    case (mode_eff)
      M_SAW:   sample = acc_q + ofs;
      M_DIR:   sample = step;
      default: sample = acc_q;
    endcase
    word = {ch_q, sample};
  end

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, step};
    acc_nx = acc_q;
    dir_nx = dir_q;
    case (mode_q)
      M_SAW: acc_nx = sum[DATA_BITS-1:0];
      M_TRI: begin
        if (!dir_q) begin
          if (sum >= {1'b0, MAXV}) begin
            acc_nx = MAXV;
            dir_nx = 1'b1;
          end else begin
            acc_nx = sum[DATA_BITS-1:0];
          end
        end else if (acc_q < step) begin
          acc_nx = '0;
          dir_nx = 1'b0;
        end else begin
          acc_nx = acc_q - step;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    dir_d    = dir_q;
    ch_d     = ch_q;
    ch_idx_d = ch_idx_q;
    mode_d   = mode_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    sdo_d    = sdo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        sdo_d  = 1'b0;
        if (enable) begin
          state_d = S_CSH;
          cnt_d   = CW'(T_CSH);
          acc_d   = '0;
          dir_d   = 1'b0;
          ch_d    = '0;
        end
      end
      S_CSH: begin
        if (cnt_q == '0) begin
          cs_d     = 1'b0;
          shift_d  = word;
          sdo_d    = word[FB-1];
          bit_d    = '0;
          ch_idx_d = ch_q;
          if (ch_q == '0) mode_d = mode;
          cnt_d    = CW'(T_CSS - 1);
          state_d  = S_CSS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CSS, S_LOW: begin
        if (cnt_q == '0) begin
          sclk_d  = 1'b1;
          cnt_d   = CW'(T_HALF - 1);
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (bit_q < BW'(FB - 1)) begin
          sclk_d  = 1'b0;
          shift_d = {shift_q[FB-2:0], 1'b0};
          sdo_d   = shift_q[FB-2];
          bit_d   = bit_q + BW'(1);
          cnt_d   = CW'(T_HALF - 1);
          state_d = S_LOW;
        end else begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          sdo_d  = 1'b0;
          done_d = 1'b1;
          ch_d   = (ch_q == LAST_CH) ? '0 : ch_q + ADDR_BITS'(1);
          if (ch_q == LAST_CH) begin
            acc_d = acc_nx;
            dir_d = dir_nx;
          end
          cnt_d   = CW'(T_CSH);
          state_d = enable ? S_CSH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      acc_q    <= '0;
      dir_q    <= 1'b0;
      ch_q     <= '0;
      ch_idx_q <= '0;
      mode_q   <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      ch_q     <= ch_d;
      ch_idx_q <= ch_idx_d;
      mode_q   <= mode_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      done_q   <= done_d;
    end
  end

  assign CS         = cs_q;
  assign SCLK       = sclk_q;
  assign SDO        = sdo_q;
  assign frame_done = done_q;
  assign ch_idx     = ch_idx_q;

endmodule

// File: doc/spi_dac_wavegen.md
# spi_dac_wavegen

Parametrised multi-channel SPI DAC waveform generator: the next generation of the single-channel sawtooth counter. It drives a serial DAC with framed words of the form {channel address, sample}, sent MSB first. Channels are served round-robin. Three waveform modes are supported: phase-offset sawtooth, triangle and direct DC level. All SPI timing is parametrised, and there is a clean stop/restart on `enable`.

## Interface
- DATA_BITS, 12, sample width.
- ADDR_BITS, 4, channel address field width; FRAME_BITS = ADDR_BITS + DATA_BITS.
- NUM_CH, 4, channels served (1..2^ADDR_BITS); must be a power of two.
- T_CSH, 2, clk cycles CS held high between frames (≥1).
- T_CSS, 1, clk cycles from CS fall to first SCLK rise (≥1).
- T_HALF, 1, clk cycles per SCLK half-period (≥1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset: one clock, reset synchronous, active-low.
- enable  in  1  run request; sampled as described below.
- mode  in  2  00 sawtooth, 01 triangle, 10 direct, 11 freeze.
- step  in  DATA_BITS  accumulator increment (sawtooth/triangle) or DC level (direct).
- CS  out  1  DAC chip select, active-low.
- SCLK  out  1  serial clock, idle low.
- SDO  out  1  serial data; DAC samples on SCLK rise.
- frame_done  out  1  one-cycle pulse on the cycle CS returns high after a complete frame.
- ch_idx  out  ADDR_BITS  channel of the frame in progress or most recently sent.

## Operation
- States: IDLE, CSH, CSS, LOW, HIGH.
  - IDLE: CS=1, SCLK=0, SDO=0. If enable=1 → CSH with counter T_CSH, and clear acc=0, dir=up, ch=0.
  - CSH: CS=1. After T_CSH cycles: CS←0, load shift register with the frame word, bit counter←0, → CSS.
  - CSS: CS=0, SCLK=0, SDO=frame MSB. After T_CSS cycles: SCLK←1, → HIGH.
  - HIGH: after T_HALF cycles:
    - If bits sent < FRAME_BITS−1: SCLK←0, shift left one bit (SDO changes with the falling edge), → LOW.
    - Otherwise: CS←1, SCLK←0, frame_done pulse, advance channel, → CSH if enable=1, else → IDLE.
  - LOW: after T_HALF cycles: SCLK←1, → HIGH.
- Frame word = {ch (ADDR_BITS), sample (DATA_BITS)}.
- Sample per mode:
  - sawtooth: (acc + ch·2^DATA_BITS/NUM_CH) mod 2^DATA_BITS.
  - triangle and freeze: acc.
  - direct: step, sampled at frame load.
- mode is latched when the ch 0 frame loads and holds for the whole sweep.
- The accumulator updates once per sweep, when the ch NUM_CH−1 frame completes, and uses step sampled at that cycle.
  - sawtooth: acc ← (acc+step) mod 2^DATA_BITS; the carry is discarded.
  - triangle: sum is DATA_BITS+1 wide.
    - Up: if acc+step ≥ MAX (2^DATA_BITS−1), acc←MAX and dir←down; else acc←acc+step.
    - Down: if acc < step, acc←0 and dir←up; else acc←acc−step.
  - direct, freeze: acc unchanged.
- Channel advance: ch wraps NUM_CH−1 → 0. ch_idx tracks ch and is updated at frame load.
- Boundaries:
  - enable falling mid-frame: the frame completes in full, then IDLE.
  - enable re-high before the frame ends: the frame continues seamlessly, without clearing acc.
  - Rising enable from IDLE always restarts from acc=0, ch=0.
  - step=0: a constant waveform.
  - rst_n low mid-frame: next edge gives CS=1, SCLK=0; the frame is truncated and no frame_done pulse is issued.

## Timing
- Reset values: CS=1, SCLK=0, SDO=0, frame_done=0, ch_idx=0, acc=0, dir=up, state IDLE.
- enable=1 sampled in IDLE → CS falls T_CSH+1 clk edges later.
- Frame period (back-to-back) = T_CSH + T_CSS + 2·T_HALF·FRAME_BITS cycles; defaults give 2+1+32 = 35.
- Exactly FRAME_BITS SCLK rising edges per CS-low window.
- SDO is stable ≥ T_HALF cycles before each SCLK rise, and held through the rise.
- CS falls only with SCLK low; CS rises on the same edge SCLK falls after the last bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Defaults for all scenarios: DATA_BITS=12, ADDR_BITS=4, NUM_CH=4, T_CSH=2, T_CSS=1, T_HALF=1.

- Reset, then enable=1, mode=00, step=100:
  - Decoded words 0x0000, 0x1400, 0x2800, 0x3C00, then 0x0064, 0x1464.
  - 35-cycle frame period, 16 SCLK rises per frame, frame_done once per frame.
- Sawtooth wrap, mode=00, step=0x800: ch 0 samples are 0x000, 0x800, 0x000; ch 1 samples are 0x400, 0xC00, 0x400.
- Triangle, mode=01, step=0x600: ch 0 samples are 0x000, 0x600, 0xC00, 0xFFF, 0x9FF, 0x3FF, 0x000, 0x600, and all channels carry an equal sample per sweep.
- Direct, mode=10, step=0xABC: words 0x0ABC, 0x1ABC, 0x2ABC, 0x3ABC repeat. Changing step to 0x123 mid-sweep shows 0x123 from the next frame load.
- enable dropped at bit 5 of a frame:
  - Frame finishes with 16 rises, then CS stays 1 and SCLK 0.
  - Re-enable restarts with word 0x0000.
- rst_n low for 1 cycle at bit 8:
  - Next edge gives CS=1, SCLK=0, SDO=0, and no frame_done.
  - With enable held high, the next frame starts at word 0x0000 after T_CSH+1 cycles.
